uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the TXTOP transmitter.
- Shares the BAUD_RATE_GENERATOR bclk tick (OVERSAMPLING ticks per bit) with the transmitter.
- Deserialises frames LSB-first: start bit, data bits, optional even/odd parity bit, one stop bit.
- Delivers the data word with a one-cycle valid pulse, plus sticky parity and framing error flags.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, oversampled start-bit
// qualification, LSB-first data capture, optional even/odd parity check
// and a single stop bit. Result word, valid pulse and sticky error flags
// are all registered.
module uart_rx #(
  parameter int DATAWIDTH    = 8,
  parameter int OVERSAMPLING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 parEnable,
  input  logic                 parityType,
  input  logic                 rx_in,
  output logic [DATAWIDTH-1:0] dataOutput,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int BIT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  // Mid-bit tick for start qualification, full-bit tick for everything else.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATAWIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Reduction parity of a data word (1 = odd number of ones).
  function automatic logic parity_of(input logic [DATAWIDTH-1:0] word);
    return ^word;
  endfunction

  logic                 sync1_r;
  logic                 rx_sync_r;
  logic                 rx_prev_r;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATAWIDTH-1:0] shreg_r;
  logic                 par_en_r;
  logic                 par_type_r;
  logic                 par_err_r;

  logic fall_s;
  logic mid_tick_s;
  logic end_tick_s;
  logic par_bad_s;

  // Falling edge is judged every clk so a break (line stuck low) cannot retrigger.
  assign fall_s     = ~rx_sync_r & rx_prev_r;
  assign mid_tick_s = bclk & (cnt_r == CNT_MID);
  assign end_tick_s = bclk & (cnt_r == CNT_END);
  assign par_bad_s  = (parity_of(shreg_r) ^ rx_sync_r) != par_type_r;

  // Two-flop synchroniser plus previous-sample flop for edge detection; idle-high reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r   <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx_in;
      rx_sync_r <= sync1_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM with tick/bit counters, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      bit_cnt_r   <= '0;
      shreg_r     <= '0;
      par_en_r    <= 1'b0;
      par_type_r  <= 1'b0;
      par_err_r   <= 1'b0;
      dataOutput  <= '0;
      dataValid   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (fall_s) begin
            state_r     <= S_START;
            rx_busy     <= 1'b1;
            // A coincident tick is not a sampling tick, so it counts in START.
            cnt_r       <= bclk ? CNT_ONE : '0;
            par_en_r    <= parEnable;
            par_type_r  <= parityType;
            par_err_r   <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
          end else begin
            cnt_r <= '0;
          end
        end
        S_START: begin
          if (mid_tick_s) begin
            cnt_r     <= '0;
            bit_cnt_r <= '0;
            if (!rx_sync_r) begin
              state_r <= S_DATA;
            end else begin
              // Line recovered before mid-bit: treat as a glitch.
              state_r <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else if (bclk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DATA: begin
          if (end_tick_s) begin
            cnt_r   <= '0;
            shreg_r <= {rx_sync_r, shreg_r[DATAWIDTH-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= '0;
              state_r   <= par_en_r ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end else if (bclk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (end_tick_s) begin
            cnt_r     <= '0;
            par_err_r <= par_bad_s;
            state_r   <= S_STOP;
          end else if (bclk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_STOP: begin
          if (end_tick_s) begin
            cnt_r       <= '0;
            dataOutput  <= shreg_r;
            frameError  <= ~rx_sync_r;
            parityError <= par_err_r;
            dataValid   <= rx_sync_r & ~par_err_r;
            state_r     <= S_IDLE;
            rx_busy     <= 1'b0;
          end else if (bclk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are described at the bit level,
// expected results are pushed per frame, and a monitor pops them each time
// the receiver leaves its busy state.
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int OS       = 4;
  localparam int BDIV     = 2;
  localparam int BIT_CLKS = OS * BDIV;

  logic          clk;
  logic          rst;
  logic          bclk;
  logic          parEnable;
  logic          parityType;
  logic          rx_in;
  logic [DW-1:0] dataOutput;
  logic          dataValid;
  logic          parityError;
  logic          frameError;
  logic          rx_busy;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] last_data;
  int            checks;
  int            errors;

  uart_rx #(.DATAWIDTH(DW), .OVERSAMPLING(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bclk       (bclk),
    .parEnable  (parEnable),
    .parityType (parityType),
    .rx_in      (rx_in),
    .dataOutput (dataOutput),
    .dataValid  (dataValid),
    .parityError(parityError),
    .frameError (frameError),
    .rx_busy    (rx_busy)
  );

  // System clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversampling tick: one clk high out of every BDIV (=2) clks.
  initial begin
    bclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bclk = ~bclk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: what a frame built from these fields must produce.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptype,
                            input logic flip_par, input logic stop_val);
    exp_t e;
    int   ones;
    logic pbit;
    ones   = $countones(d);
    // Transmitter's parity bit makes total ones odd exactly when ptype = 1.
    pbit   = ((ones % 2) == 1) ^ ptype ^ flip_par;
    e.data = d;
    e.perr = pen && ((((ones + int'(pbit)) % 2) == 1) != ptype);
    e.ferr = ~stop_val;
    e.valid = stop_val && !e.perr;
    last_data = d;
    exp_q.push_back(e);
    parEnable  = pen;
    parityType = ptype;
    drive_bit(1'b0);
    // Configuration changes after start detection must not affect this frame.
    parEnable  = 1'($urandom);
    parityType = 1'($urandom);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop_val);
  endtask

  task automatic glitch();
    exp_t e;
    e.data  = last_data;
    e.valid = 1'b0;
    e.perr  = 1'b0;
    e.ferr  = 1'b0;
    exp_q.push_back(e);
    rx_in = 1'b0;
    repeat (BDIV) @(posedge clk);
    #1;
    idle(3 * BIT_CLKS);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(dataOutput),  32'd0);
    check({tag, "_valid"}, 32'(dataValid),   32'd0);
    check({tag, "_perr"},  32'(parityError), 32'd0);
    check({tag, "_ferr"},  32'(frameError),  32'd0);
    check({tag, "_busy"},  32'(rx_busy),     32'd0);
  endtask

  // Monitor: each busy->idle transition is one frame outcome; valid is never allowed elsewhere.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !rx_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("data",  32'(dataOutput),  32'(e.data));
            check("valid", 32'(dataValid),   32'(e.valid));
            check("perr",  32'(parityError), 32'(e.perr));
            check("ferr",  32'(frameError),  32'(e.ferr));
          end
        end else if (dataValid) begin
          check("stray_valid", 32'(dataValid), 32'd0);
        end
        prev_busy = rx_busy;
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized frames.
  initial begin
    logic [DW-1:0] d;
    logic          pen;
    logic          ptype;
    int            kind;
    checks     = 0;
    errors     = 0;
    last_data  = '0;
    rst        = 1'b0;
    rx_in      = 1'b1;
    parEnable  = 1'b0;
    parityType = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    idle(2 * BIT_CLKS);

    // Parity off.
    send_frame(8'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    // Even parity, natural parity bits 0 and 1.
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    send_frame(8'hEF, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    // Even parity, parity bit forced wrong (0 instead of 1).
    send_frame(8'hB9, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2 * BIT_CLKS);
    // Stop bit 0 followed by a held-low break: no restart while low.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("break_busy", 32'(rx_busy), 32'd0);
    idle(2 * BIT_CLKS);
    // Short low glitch, then a good frame.
    glitch();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    wait_drain();

    // Reset in the middle of the data bits abandons the frame.
    parEnable = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    last_data = '0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * BIT_CLKS);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);

    // Randomized frames: clean, bad parity, bad stop; occasional glitch.
    for (int n = 0; n < 40; n++) begin
      d     = DW'($urandom_range(0, 255));
      pen   = 1'($urandom_range(0, 1));
      ptype = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 4);
      if (kind == 4) begin
        glitch();
      end else begin
        send_frame(d, pen, ptype, pen && (kind == 1), kind != 2);
        idle(BIT_CLKS + $urandom_range(0, BIT_CLKS));
      end
    end

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
